spart_driver: RTL and testbench



---
 rtl/spart_pkg.sv | 32 +++
 rtl/spart_driver.sv | 126 ++++++++++++
 tb/tb_spart_driver.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
// Shared SPART bus definitions: register addresses, driver FSM states, baud divisor helper.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF   = 2'b00;
  localparam logic [1:0] ADDR_STAT  = 2'b01;
  localparam logic [1:0] ADDR_DIVLO = 2'b10;
  localparam logic [1:0] ADDR_DIVHI = 2'b11;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    READ,
    WAIT_TBR,
    WRITE
  } drv_state_t;

  // Rounded divisor for a 16x oversampling baud generator: round(clk / (16 * baud)).
  function automatic logic [15:0] baud_div(input longint unsigned clk_hz, input logic [1:0] br_cfg);
    longint unsigned baud;
    longint unsigned div;
    case (br_cfg)
      2'b00:   baud = 64'd4800;
      2'b01:   baud = 64'd9600;
      2'b10:   baud = 64'd19200;
      default: baud = 64'd38400;
    endcase
    div = (clk_hz + 64'd8 * baud) / (64'd16 * baud);
    return div[15:0];
  endfunction

endpackage

// File: rtl/spart_driver.sv
// SPART bus initiator: programs the baud divisor after reset / br_cfg change, then echoes each received byte.
// Optional SPART_DRV_UPCASE_EN: echo lowercase ASCII as uppercase (last_rx keeps the raw byte).
module spart_driver
  import spart_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] last_rx,
  output logic [7:0] rx_count
);

  drv_state_t r_state;
  drv_state_t w_next;
  logic [1:0] r_br_cur;
  logic [7:0] r_tx_byte;
  logic [7:0] r_last_rx;
  logic [7:0] r_rx_count;

  logic       w_acc;
  logic       w_rw;
  logic [1:0] w_addr;
  logic [7:0] w_wdat;
  logic       w_br_load;
  logic [15:0] w_div;
  logic [7:0] w_echo;

  assign w_div = baud_div(longint'(CLK_HZ), r_br_cur);

`ifdef SPART_DRV_UPCASE_EN
  assign w_echo = (databus >= 8'h61 && databus <= 8'h7A) ? (databus - 8'h20) : databus;
`else
  assign w_echo = databus;
`endif

  always_comb begin
    w_next    = r_state;
    w_acc     = 1'b0;
    w_rw      = 1'b1;
    w_addr    = ADDR_BUF;
    w_wdat    = 8'h00;
    w_br_load = 1'b0;
    case (r_state)
      CFG_LO: begin
        w_acc  = 1'b1;
        w_rw   = 1'b0;
        w_addr = ADDR_DIVLO;
        w_wdat = w_div[7:0];
        w_next = CFG_HI;
      end
      CFG_HI: begin
        w_acc  = 1'b1;
        w_rw   = 1'b0;
        w_addr = ADDR_DIVHI;
        w_wdat = w_div[15:8];
        w_next = IDLE;
      end
      IDLE: begin
        // A pending baud change wins over received data so the link is never serviced at a stale rate.
        if (br_cfg != r_br_cur) begin
          w_br_load = 1'b1;
          w_next    = CFG_LO;
        end else if (rda) begin
          w_next = READ;
        end
      end
      READ: begin
        w_acc  = 1'b1;
        w_rw   = 1'b1;
        w_addr = ADDR_BUF;
        w_next = WAIT_TBR;
      end
      WAIT_TBR: begin
        if (tbr) begin
          w_next = WRITE;
        end
      end
      WRITE: begin
        w_acc  = 1'b1;
        w_rw   = 1'b0;
        w_addr = ADDR_BUF;
        w_wdat = r_tx_byte;
        w_next = IDLE;
      end
      default: w_next = CFG_LO;
    endcase
  end

  // Reset parks the FSM in CFG_LO; masking the bus with rst keeps it quiet until release.
  assign iocs    = w_acc & ~rst;
  assign iorw    = w_rw | rst;
  assign ioaddr  = rst ? ADDR_BUF : w_addr;
  assign databus = (iocs && !iorw) ? w_wdat : 8'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= CFG_LO;
      r_br_cur   <= br_cfg;
      r_tx_byte  <= 8'h00;
      r_last_rx  <= 8'h00;
      r_rx_count <= 8'h00;
    end else begin
      r_state <= w_next;
      if (w_br_load) begin
        r_br_cur <= br_cfg;
      end
      if (r_state == READ) begin
        r_last_rx  <= databus;
        r_tx_byte  <= w_echo;
        r_rx_count <= r_rx_count + 8'd1;
      end
    end
  end

  assign last_rx  = r_last_rx;
  assign rx_count = r_rx_count;

endmodule

// File: tb/tb_spart_driver.sv
// Scoreboard bench for spart_driver: stimulus queues expected bus accesses, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_spart_driver;

  typedef struct packed {
    logic       rw;
    logic [1:0] addr;
    logic [7:0] dat;
  } acc_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b00;
  logic       rda = 1'b0;
  logic       tbr = 1'b1;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] last_rx;
  logic [7:0] rx_count;
  logic [7:0] rx_dat = 8'h00;

  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rd_cyc = -1;
  int   wr_cyc = -1;
  acc_t exp_q[$];

  spart_driver #(.CLK_HZ(50000000)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .last_rx(last_rx), .rx_count(rx_count)
  );

  // SPART model: drives the receive buffer onto the bus during reads.
  assign databus = (iocs && iorw) ? rx_dat : 8'bz;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] echo_of(input logic [7:0] b);
`ifdef SPART_DRV_UPCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
    return b;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_cfg(input logic [7:0] lo, input logic [7:0] hi);
    exp_q.push_back('{rw: 1'b0, addr: 2'b10, dat: lo});
    exp_q.push_back('{rw: 1'b0, addr: 2'b11, dat: hi});
  endtask

  // One-cycle rda pulse while the DUT idles; returns the cycle rda was seen.
  task automatic rx_byte(input logic [7:0] b, input logic expect_echo, output int n);
    rx_dat = b;
    exp_q.push_back('{rw: 1'b1, addr: 2'b00, dat: b});
    if (expect_echo) exp_q.push_back('{rw: 1'b0, addr: 2'b00, dat: echo_of(b)});
    n = cyc;
    rda = 1'b1;
    tick(1);
    rda = 1'b0;
  endtask

  // Monitor: every access must match the head of the scoreboard.
  always @(negedge clk) begin
    if (iocs) begin
      acc_t got;
      acc_t req;
      got = '{rw: iorw, addr: ioaddr, dat: databus};
      n_chk++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_access: got rw=%0b addr=%0d dat=0x%0h expected none", iorw, ioaddr, databus);
      end else begin
        req = exp_q.pop_front();
        if (got !== req) begin
          n_bad++;
          $display("FAIL bus_access: got rw=%0b addr=%0d dat=0x%0h expected rw=%0b addr=%0d dat=0x%0h",
                   got.rw, got.addr, got.dat, req.rw, req.addr, req.dat);
        end
      end
      if (iorw) rd_cyc = cyc;
      else if (ioaddr == 2'b00) wr_cyc = cyc;
    end
  end

  initial begin
    int n;
    int m;
    tick(3);
    check("reset_iocs", {15'd0, iocs}, 16'd0);
    check("reset_iorw", {15'd0, iorw}, 16'd1);
    check("reset_last_rx", {8'd0, last_rx}, 16'h0000);
    check("reset_rx_count", {8'd0, rx_count}, 16'h0000);

    // Divisor for 4800 baud = 0x028B.
    push_cfg(8'h8B, 8'h02);
    rst = 1'b0;
    tick(6);
    check("cfg_drained", 16'(exp_q.size()), 16'd0);

    // Echo with transmitter ready: read at N+1, write at N+3.
    tbr = 1'b1;
    rx_byte(8'hB4, 1'b1, n);
    tick(6);
    check("echo_rd_lat", 16'(rd_cyc - n), 16'd1);
    check("echo_wr_lat", 16'(wr_cyc - n), 16'd3);
    check("echo_last_rx", {8'd0, last_rx}, 16'h00B4);
    check("echo_rx_count", {8'd0, rx_count}, 16'd1);
    check("echo_drained", 16'(exp_q.size()), 16'd0);

    // Transmitter busy for 50 cycles; a reverting baud glitch must not reconfigure.
    tbr = 1'b0;
    rx_byte(8'h41, 1'b1, n);
    tick(10);
    br_cfg = 2'b01;
    tick(3);
    br_cfg = 2'b00;
    tick(37);
    check("hold_write_pending", 16'(exp_q.size()), 16'd1);
    m = cyc;
    tbr = 1'b1;
    tick(4);
    check("hold_wr_lat", 16'(wr_cyc - m), 16'd1);
    check("hold_last_rx", {8'd0, last_rx}, 16'h0041);
    check("hold_drained", 16'(exp_q.size()), 16'd0);

    // Baud change during WAIT_TBR: echo first, then 38400 divisor 0x0051.
    tbr = 1'b0;
    rx_byte(8'h5A, 1'b1, n);
    tick(3);
    br_cfg = 2'b11;
    push_cfg(8'h51, 8'h00);
    tick(5);
    tbr = 1'b1;
    tick(8);
    check("brchg_drained", 16'(exp_q.size()), 16'd0);
    check("brchg_rx_count", {8'd0, rx_count}, 16'd3);

    // Reset while waiting for tbr: write dropped, divisor reprogrammed, count cleared.
    tbr = 1'b0;
    rx_byte(8'h33, 1'b0, n);
    tick(3);
    rst = 1'b1;
    tick(2);
    check("rst_mid_iocs", {15'd0, iocs}, 16'd0);
    push_cfg(8'h51, 8'h00);
    rst = 1'b0;
    tick(1);
    tbr = 1'b1;
    tick(8);
    check("rst_mid_rx_count", {8'd0, rx_count}, 16'd0);
    check("rst_mid_last_rx", {8'd0, last_rx}, 16'h0000);
    check("rst_mid_drained", 16'(exp_q.size()), 16'd0);

    // Lowercase boundary bytes: 0x61 (upcased when enabled) and 0x7B (never).
    rx_byte(8'h61, 1'b1, n);
    tick(6);
    rx_byte(8'h7B, 1'b1, n);
    tick(6);
    check("case_last_rx", {8'd0, last_rx}, 16'h007B);
    check("case_rx_count", {8'd0, rx_count}, 16'd2);
    check("case_drained", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
